// File: rtl/shift_rows_pipe.sv
// AES/Rijndael ShiftRows behind a 1- or 2-stage valid/ready pipeline.
// Define SHIFT_ROWS_INV_EN to build InvShiftRows, selected per block by in_inv.
module shift_rows_pipe #(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [15:0]       blk_cnt
);
    localparam int unsigned W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1 or 2");
    end

    logic [W-1:0] perm_c;
    logic         v1_q, v1_d;
    logic [W-1:0] d1_q, d1_d;
    logic         adv1_c;
    logic         rdy1_c;
    logic [15:0]  cnt_q, cnt_d;

`ifndef SHIFT_ROWS_INV_EN
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    // Byte-level row rotation; byte k = 4*c+r sits at the MSB end for k = 0
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned OFF = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int unsigned FWD = (c + OFF) % NB;
`ifdef SHIFT_ROWS_INV_EN
            localparam int unsigned INV = (c + NB - OFF) % NB;
            assign perm_c[W-1-8*(4*c+r) -: 8] = in_inv ? in_data[W-1-8*(4*INV+r) -: 8]
                                                       : in_data[W-1-8*(4*FWD+r) -: 8];
`else
            assign perm_c[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*FWD+r) -: 8];
`endif
        end
    end

    // Optional second stage only holds data; adv1_c says whether stage 1 may drain
    if (STAGES == 2) begin : g_two
        logic         v2_q, v2_d;
        logic [W-1:0] d2_q, d2_d;

        assign adv1_c = !v2_q || out_ready;

        always_comb begin
            v2_d = v2_q;
            d2_d = d2_q;
            if (adv1_c) begin
                v2_d = v1_q;
                if (v1_q) d2_d = d1_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v2_d;
                d2_q <= d2_d;
            end
        end

        assign out_valid = v2_q;
        assign out_data  = d2_q;
    end else begin : g_one
        assign adv1_c    = out_ready;
        assign out_valid = v1_q;
        assign out_data  = d1_q;
    end

    assign rdy1_c   = !v1_q || adv1_c;
    assign in_ready = rdy1_c;
    assign blk_cnt  = cnt_q;

    always_comb begin
        v1_d  = v1_q;
        d1_d  = d1_q;
        cnt_d = cnt_q;
        if (rdy1_c) begin
            v1_d = in_valid;
            if (in_valid) d1_d = perm_c;
        end
        if (out_valid && out_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4/STAGES=1 and NB=8/STAGES=2 instances.
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cyc;

    logic         in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a;
    logic [127:0] in_data_a, out_data_a;
    logic [15:0]  blk_cnt_a;
    logic         in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b;
    logic [255:0] in_data_b, out_data_b;
    logic [15:0]  blk_cnt_b;

    logic [255:0] qa[$];
    logic [255:0] qb[$];
    int           out_cyc_a[$];
    bit           rr_a, rr_b;

    shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_inv(in_inv_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .blk_cnt(blk_cnt_a)
    );

    shift_rows_pipe #(.NB(8), .STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_inv(in_inv_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .blk_cnt(blk_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: view the state as a 4 x nb byte matrix and rotate each row
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
        logic [7:0]   st [4][8];
        logic [255:0] res;
        int           off [4];
        int           src;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[8*(4*nb-1-(4*c+r)) +: 8];
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                res[8*(4*nb-1-(4*c+r)) +: 8] = st[r][src];
            end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // Expected results enter the scoreboard on accepted input transfers
    always @(negedge clk) begin
        if (rst_n && in_valid_a && in_ready_a)
            qa.push_back(ref_shift(256'(in_data_a), 4, INV_EN && in_inv_a));
        if (rst_n && in_valid_b && in_ready_b)
            qb.push_back(ref_shift(in_data_b, 8, INV_EN && in_inv_b));
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            out_cyc_a.push_back(cyc);
            if (qa.size() == 0) fail_now("a_spurious_output");
            else check("a_out_data", 256'(out_data_a), qa.pop_front());
        end
        if (rst_n && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) fail_now("b_spurious_output");
            else check("b_out_data", out_data_b, qb.pop_front());
        end
    end

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
    end

    always @(posedge clk) begin
        #1;
        if (rr_a) out_ready_a = ($urandom % 4) != 0;
        if (rr_b) out_ready_b = ($urandom % 2) != 0;
    end

    task automatic send_a(input logic [127:0] d, input logic inv);
        int t;
        t = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_inv_a   = inv;
        forever begin
            @(negedge clk);
            if (in_ready_a) break;
            t++;
            if (t > 200) begin fail_now("a_send_timeout"); break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [255:0] d, input logic inv);
        int t;
        t = 0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        in_inv_b   = inv;
        forever begin
            @(negedge clk);
            if (in_ready_b) break;
            t++;
            if (t > 200) begin fail_now("b_send_timeout"); break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int t;
        t = 0;
        while (qa.size() != 0 || out_valid_a) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin fail_now("a_drain_timeout"); break; end
        end
    endtask

    task automatic drain_b();
        int t;
        t = 0;
        while (qb.size() != 0 || out_valid_b) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin fail_now("b_drain_timeout"); break; end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    logic [255:0] dvec;
    logic [255:0] hold;
    logic [63:0]  row2, row3;
    int           acc;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        rr_a = 1'b0; rr_b = 1'b0;
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; in_inv_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; in_inv_b = 1'b0; out_ready_b = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out_valid", 256'(out_valid_a), 256'(0));
        check("rst_a_blk_cnt",   256'(blk_cnt_a),   256'(0));
        check("rst_a_out_data",  256'(out_data_a),  256'(0));
        check("rst_a_in_ready",  256'(in_ready_a),  256'(1));
        check("rst_b_out_valid", 256'(out_valid_b), 256'(0));
        check("rst_b_blk_cnt",   256'(blk_cnt_b),   256'(0));
        check("rst_b_out_data",  out_data_b,        256'(0));
        check("rst_b_in_ready",  256'(in_ready_b),  256'(1));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known AES vector, forward, single-stage latency
        send_a(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
        in_valid_a = 1'b0;
        check("a_fwd_latency_valid", 256'(out_valid_a), 256'(1));
        check("a_fwd_vector", 256'(out_data_a), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        @(posedge clk);
        #1;
        check("a_blk_cnt_one", 256'(blk_cnt_a), 256'(1));
        check("a_idle_valid",  256'(out_valid_a), 256'(0));

        send_a(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
        in_valid_a = 1'b0;
`ifdef SHIFT_ROWS_INV_EN
        check("a_inv_vector", 256'(out_data_a), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
`endif
        @(posedge clk);
        #1;

        // Alternating mode, back-to-back
        out_cyc_a.delete();
        for (int i = 0; i < 8; i++) send_a(rnd128(), 1'(i % 2));
        in_valid_a = 1'b0;
        drain_a();
        check("a_burst_count", 256'(out_cyc_a.size()), 256'(8));
        if (out_cyc_a.size() == 8)
            check("a_burst_no_bubble", 256'(out_cyc_a[7] - out_cyc_a[0]), 256'(7));

        // Random traffic with downstream back-pressure
        rr_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 4) == 0) begin
                in_valid_a = 1'b0;
                @(posedge clk);
                #1;
            end
            send_a(rnd128(), 1'($urandom % 2));
        end
        in_valid_a = 1'b0;
        rr_a = 1'b0;
        out_ready_a = 1'b1;
        drain_a();

        // NB=8 ascending bytes: row 2 offset 3, row 3 offset 4
        for (int k = 0; k < 32; k++) dvec[255-8*k -: 8] = 8'(k);
        send_b(dvec, 1'b0);
        in_valid_b = 1'b0;
        check("b_latency_stage1", 256'(out_valid_b), 256'(0));
        @(posedge clk);
        #1;
        check("b_latency_stage2", 256'(out_valid_b), 256'(1));
        row2 = '0;
        row3 = '0;
        for (int c = 0; c < 8; c++) begin
            row2 = {row2[55:0], out_data_b[255-8*(4*c+2) -: 8]};
            row3 = {row3[55:0], out_data_b[255-8*(4*c+3) -: 8]};
        end
        check("b_row2_offset3", 256'(row2), 256'(64'h0E12161A1E02060A));
        check("b_row3_offset4", 256'(row3), 256'(64'h13171B1F03070B0F));
        @(posedge clk);
        #1;

        // Stall: only two blocks fit, output held stable
        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        in_inv_b    = 1'b0;
        in_data_b   = rnd256();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready_b) acc++;
            @(posedge clk);
            #1;
            in_data_b = rnd256();
            in_inv_b  = 1'($urandom % 2);
        end
        check("b_stall_accepted", 256'(acc), 256'(2));
        @(negedge clk);
        check("b_stall_in_ready", 256'(in_ready_b), 256'(0));
        hold = out_data_b;
        @(posedge clk);
        @(negedge clk);
        check("b_stall_data_stable", out_data_b, hold);
        check("b_stall_valid_held", 256'(out_valid_b), 256'(1));
        @(posedge clk);
        #1;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        drain_b();
        check("b_blk_cnt_after_stall", 256'(blk_cnt_b), 256'(3));

        // Random traffic on the two-stage instance
        rr_b = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (($urandom % 3) == 0) begin
                in_valid_b = 1'b0;
                @(posedge clk);
                #1;
            end
            send_b(rnd256(), 1'($urandom % 2));
        end
        in_valid_b = 1'b0;
        rr_b = 1'b0;
        out_ready_b = 1'b1;
        drain_b();

        // Asynchronous reset with two blocks in flight
        out_ready_b = 1'b0;
        send_b(rnd256(), 1'b0);
        send_b(rnd256(), 1'b1);
        in_valid_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_b_out_valid", 256'(out_valid_b), 256'(0));
        check("arst_b_blk_cnt",   256'(blk_cnt_b),   256'(0));
        check("arst_b_in_ready",  256'(in_ready_b),  256'(1));
        check("arst_b_out_data",  out_data_b,        256'(0));
        check("arst_a_blk_cnt",   256'(blk_cnt_a),   256'(0));
        out_ready_b = 1'b1;
        @(posedge clk);
        #3;
        in_valid_b = 1'b1;
        in_data_b  = rnd256();
        in_inv_b   = 1'b1;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        check("post_rst_stage1", 256'(out_valid_b), 256'(0));
        @(posedge clk);
        #1;
        check("post_rst_first_edge_accept", 256'(out_valid_b), 256'(1));
        drain_b();
        check("post_rst_b_blk_cnt", 256'(blk_cnt_b), 256'(1));

        // Counter wrap on the single-stage instance
        out_ready_a = 1'b1;
        for (int i = 0; i < 65535; i++) send_a(rnd128(), 1'($urandom % 2));
        in_valid_a = 1'b0;
        drain_a();
        check("a_blk_cnt_ffff", 256'(blk_cnt_a), 256'(16'hFFFF));
        send_a(rnd128(), 1'b0);
        in_valid_a = 1'b0;
        drain_a();
        check("a_blk_cnt_wrap", 256'(blk_cnt_a), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, state columns (legal 4, 6, 8); any other value SHALL fail elaboration.
REQ-002 SHALL have parameter STAGES, default 1, pipeline register stages (legal 1 or 2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_data/in_inv valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_data  input  32*NB  state, column-major; byte k = 4*c+r occupies bits [32*NB-1-8k -: 8] (byte 0 at MSB).
REQ-008 SHALL have port in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts output.
REQ-011 SHALL have port out_data  output  32*NB  transformed state, same byte layout.
REQ-012 SHALL have port blk_cnt  output  16  count of completed output transfers.

Function
REQ-013 Row r shift offset C_r SHALL be 0,1,2,3 for NB=4 or 6, and 0,1,3,4 for NB=8 (Rijndael).
REQ-014 Forward SHALL produce out[r][c] = in[r][(c+C_r) mod NB]; inverse SHALL produce out[r][c] = in[r][(c-C_r+NB) mod NB].
REQ-015 in_inv SHALL be sampled with in_data on the input transfer and travel with that block; mode SHALL be changeable block-to-block with no bubble.
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Each stage SHALL hold a valid flag; a stage SHALL load when empty or when its contents move on the same cycle.
REQ-018 in_ready SHALL be combinational: !v_first || (stage ahead can advance); all stages full with out_ready=0 SHALL give in_ready=0.
REQ-019 Latency SHALL be STAGES cycles from input transfer to out_valid with out_ready held high; throughput one block per cycle.
REQ-020 While out_valid && !out_ready, out_data SHALL remain stable and no block SHALL be dropped or duplicated.
REQ-021 Simultaneous input and output transfer on a full pipeline SHALL advance all stages in one cycle.
REQ-022 blk_cnt SHALL increment by 1 per output transfer and wrap 16'hFFFF -> 16'h0000.
REQ-023 Permutation SHALL be applied on the input side of stage 1; later stages SHALL only hold data.

Reset
REQ-024 rst_n low SHALL asynchronously clear all valid flags, out_valid=0, blk_cnt=0; in_ready=1 during and after reset.
REQ-025 Data registers SHALL not require reset; out_data SHALL be 0 after reset.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight blocks; no output transfer SHALL occur for them.
REQ-027 Release of rst_n SHALL be synchronised externally; the block SHALL accept input on the first clock edge after release.

Configuration
REQ-028 Macro SHIFT_ROWS_INV_EN SHALL control inverse support.
REQ-029 With SHIFT_ROWS_INV_EN defined, REQ-014/015 inverse behaviour SHALL be built.
REQ-030 Without it, in_inv SHALL remain a port but be ignored, all blocks forward-shifted, and no inverse mux logic synthesised.

Verification
REQ-031 NB=4, STAGES=1, in_inv=0, in_data=d42711aee0bf98f1b8b45de51e415230, out_ready=1 -> next cycle out_valid=1, out_data=d4bf5d30e0b452aeb84111f11e2798e5, blk_cnt=1.
REQ-032 Same, in_inv=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230; alternate in_inv each cycle for 8 blocks -> 8 correct outputs back-to-back, no bubble.
REQ-033 NB=8, in_data bytes 00..1F ascending, forward -> row 2 of output = bytes 0E,12,16,1A,1E,02,06,0A (offset 3), row 3 offset 4.
REQ-034 STAGES=2, out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 blocks accepted, in_ready=0 thereafter, out_data stable; release -> both emitted in order.
REQ-035 rst_n pulsed low mid-stream with 2 blocks in flight -> out_valid=0 and blk_cnt=0 immediately (asynchronously); preloaded blk_cnt=FFFF plus one transfer -> 0000.
